// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x WIDTH register file with one write port and
// NREAD independent combinational read ports. Register DEPTH-1 is a
// hard-wired zero register: it always reads 0 and writes to it are dropped.
//
// Optional feature macro: REGFILE_WR_BYPASS_EN
//   defined   -> a read of the index being written in the same cycle returns
//                wr_data (write-to-read forwarding, suppressed during reset
//                and for the zero register).
//   undefined -> no forwarding; a same-cycle read returns the stored value.
module regfile_multiport #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [NREAD-1:0][$clog2(DEPTH)-1:0] rd_addr,
    output logic [NREAD-1:0][WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Only a strobed write to a real (non-zero) register changes the array;
    // address/data are not even looked at while wr_en is low.
    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr != ZERO_IDX);

    // Next-state: copy of the array with at most one entry replaced.
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Array state register; reset clears everything and beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // One DEPTH:1 mux per read port, purely combinational from rd_addr.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [WIDTH-1:0] stored;
        assign stored = (rd_addr[p] == ZERO_IDX) ? '0 : mem_q[rd_addr[p]];
`ifdef REGFILE_WR_BYPASS_EN
        // Forward the in-flight write; wr_hit already excludes the zero register.
        logic fwd;
        assign fwd = wr_hit && !reset && (rd_addr[p] == wr_addr);
        assign rd_data[p] = fwd ? wr_data : stored;
`else
        assign rd_data[p] = stored;
`endif
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default 64x32x2 instance plus a
// 32-bit x16 x3-port instance. Expectations for same-cycle reads follow the
// REGFILE_WR_BYPASS_EN build selection.
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Default-parameter instance.
    logic             reset;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [63:0]      wr_data;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][63:0] rd_data;

    regfile_multiport dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Reduced instance: WIDTH=32, DEPTH=16, NREAD=3.
    logic             s_reset;
    logic             s_wr_en;
    logic [3:0]       s_wr_addr;
    logic [31:0]      s_wr_data;
    logic [2:0][3:0]  s_rd_addr;
    logic [2:0][31:0] s_rd_data;

    regfile_multiport #(.WIDTH(32), .DEPTH(16), .NREAD(3)) dut_s (
        .clk     (clk),
        .reset   (s_reset),
        .wr_en   (s_wr_en),
        .wr_addr (s_wr_addr),
        .wr_data (s_wr_data),
        .rd_addr (s_rd_addr),
        .rd_data (s_rd_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    logic [63:0] exp_v;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        s_reset = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0;
        #2;
        tick();
        reset = 1'b0;
        s_reset = 1'b0;

        // Reset state.
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd17; #1;
        check("reset_state_p0_r0", rd_data[0], 64'h0);
        check("reset_state_p1_r17", rd_data[1], 64'h0);

        // Preload 0..30 with nonzero data, confirm a sample, then pulse reset.
        for (int i = 0; i < 31; i++) write(5'(i), 64'h0101_0101_0000_0000 | 64'(i + 1));
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd30; #1;
        check("preload_r4", rd_data[0], 64'h0101_0101_0000_0005);
        check("preload_r30", rd_data[1], 64'h0101_0101_0000_001F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr[0] = 5'(i); rd_addr[1] = 5'(31 - i); #1;
            check($sformatf("after_reset_p0_r%0d", i), rd_data[0], 64'h0);
            check($sformatf("after_reset_p1_r%0d", 31 - i), rd_data[1], 64'h0);
        end

        // Write then read sweep.
        write(5'd0, 64'h0000_0000_0000_00A0);
        write(5'd3, 64'h0000_0000_0000_000F);
        for (int i = 0; i < 32; i++) begin
            rd_addr[0] = 5'(i); #1;
            exp_v = (i == 0) ? 64'hA0 : (i == 3) ? 64'hF : 64'h0;
            check($sformatf("sweep_r%0d", i), rd_data[0], exp_v);
        end

        // Zero register: same-cycle and next-cycle reads stay 0.
        rd_addr[0] = 5'd31; rd_addr[1] = 5'd31;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hDEAD_BEEF_DEAD_BEEF; #1;
        check("zero_reg_same_cycle_p0", rd_data[0], 64'h0);
        tick();
        wr_en = 1'b0;
        check("zero_reg_p0", rd_data[0], 64'h0);
        check("zero_reg_p1", rd_data[1], 64'h0);

        // Same-cycle hazard on reg 5.
        write(5'd5, 64'h11);
        rd_addr[1] = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h22; #1;
`ifdef REGFILE_WR_BYPASS_EN
        exp_v = 64'h22;
`else
        exp_v = 64'h11;
`endif
        check("hazard_same_cycle", rd_data[1], exp_v);
        tick();
        wr_en = 1'b0;
        check("hazard_next_cycle", rd_data[1], 64'h22);

        // Reset versus write on reg 7 (holds 0x77 beforehand).
        write(5'd7, 64'h77);
        rd_addr[0] = 5'd7;
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55; #1;
        check("reset_vs_write_no_fwd", rd_data[0], 64'h77);
        tick();
        reset = 1'b0; wr_en = 1'b0;
        check("reset_vs_write_r7", rd_data[0], 64'h0);
        check("reset_vs_write_r5", rd_data[1], 64'h0);

        // Writes resume on the first edge without reset; both ports on one index.
        write(5'd7, 64'h99);
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; #1;
        check("resume_p0", rd_data[0], 64'h99);
        check("resume_p1", rd_data[1], 64'h99);

        // X on address/data with wr_en low must not disturb anything.
        wr_en = 1'b0; wr_addr = 'x; wr_data = 'x;
        tick();
        rd_addr[1] = 5'd0; #1;
        check("idle_x_r7", rd_data[0], 64'h99);
        check("idle_x_r0", rd_data[1], 64'h0);
        wr_addr = '0; wr_data = '0;

        // Reduced instance: i+1 into reg i, plus a dropped write to reg 15.
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = 32'(i + 1);
            tick();
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_rd_addr[0] = 4'(i); s_rd_addr[1] = 4'(15 - i); s_rd_addr[2] = 4'(i); #1;
            exp_v = (i == 15) ? 64'h0 : 64'(i + 1);
            check($sformatf("param_p0_r%0d", i), 64'(s_rd_data[0]), exp_v);
            check($sformatf("param_p2_r%0d", i), 64'(s_rd_data[2]), exp_v);
            exp_v = (i == 0) ? 64'h0 : 64'(16 - i);
            check($sformatf("param_p1_r%0d", 15 - i), 64'(s_rd_data[1]), exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 64: bits per register.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, a power of two and at least 2.
REQ-003 SHALL have parameter NREAD, default 2: number of independent read ports, at least 1.
REQ-004 SHALL derive localparam AW = $clog2(DEPTH) as the address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-008 SHALL have port wr_addr, input, AW bits: write register index.
REQ-009 SHALL have port wr_data, input, WIDTH bits: write value.
REQ-010 SHALL have port rd_addr, input, [NREAD-1:0][AW-1:0]: read index per port.
REQ-011 SHALL have port rd_data, output, [NREAD-1:0][WIDTH-1:0]: read value per port.

Function
REQ-012 SHALL hold a storage array of DEPTH x WIDTH flops.
REQ-013 SHALL treat register DEPTH-1 as the zero register: reads return all zeros and writes to it are discarded.
REQ-014 SHALL, on a rising clk edge with wr_en=1, reset=0 and wr_addr!=DEPTH-1, load wr_data into register wr_addr; all other registers hold.
REQ-015 SHALL leave the array unchanged on a rising edge with wr_en=0.
REQ-016 SHALL drive each rd_data[p] combinationally from rd_addr[p], with zero-cycle latency and no clock dependency on the read path.
REQ-017 SHALL let every read port select any register independently, including several ports reading the same index.
REQ-018 SHALL have a read port whose address equals wr_addr in the write cycle return per REQ-029/REQ-030; the new value is visible on all ports from the cycle after the edge.
REQ-019 SHALL ignore X on wr_addr and wr_data while wr_en=0, with no state change.
REQ-020 SHALL be parametrisable without edits; each read port is a DEPTH:1 WIDTH-bit mux built from a generate loop.

Reset
REQ-021 SHALL, on a rising edge with reset=1, clear every register to 0, overriding any simultaneous write.
REQ-022 SHALL drive all rd_data to 0 for any rd_addr in the cycle after the reset edge.
REQ-023 SHALL accept a reset asserted mid-sequence; a write presented in the same cycle as reset is lost and is not replayed.
REQ-024 SHALL resume normal writes on the first rising edge with reset=0.

Configuration
REQ-025 SHALL recognise macro REGFILE_WR_BYPASS_EN.
REQ-026 SHALL, with the macro defined, forward wr_data to rd_data[p] combinationally when wr_en=1, reset=0, rd_addr[p]==wr_addr and wr_addr!=DEPTH-1.
REQ-027 SHALL, with the macro defined, return 0 on a port reading DEPTH-1 even when that index is being written.
REQ-028 SHALL, with the macro defined, not forward when reset=1; the read returns stored contents.
REQ-029 SHALL, with the macro defined, treat a same-cycle read of the written index as returning wr_data.
REQ-030 SHALL, without the macro, have no bypass logic; a same-cycle read of the written index returns the old stored value.

Verification
REQ-031 SHALL cover reset: preload regs 0..30 with nonzero data, pulse reset for 1 cycle -> all 32 indices read 64'h0 on both ports.
REQ-032 SHALL cover write then read: write 64'h00000000000000A0 to reg 0 and 64'h000000000000000F to reg 3, then sweep rd_addr[0] over 0..31 -> 0xA0 at index 0, 0xF at index 3, 0 elsewhere.
REQ-033 SHALL cover the zero register: write 64'hDEADBEEFDEADBEEF to reg 31 -> next cycle reg 31 reads 0 on both ports.
REQ-034 SHALL cover the same-cycle hazard: reg 5 holds 0x11; write 0x22 to reg 5 while rd_addr[1]=5 -> that cycle reads 0x22 with REGFILE_WR_BYPASS_EN and 0x11 without; next cycle reads 0x22 in both builds.
REQ-035 SHALL cover reset versus write: assert reset and wr_en together writing 0x55 to reg 7 -> reg 7 reads 0, with no forwarding of 0x55 in either build.
REQ-036 SHALL cover parametrisation: instantiate WIDTH=32, DEPTH=16, NREAD=3 and write i+1 to each reg i for i=0..14 -> all 3 ports read i+1 at index i and 0 at index 15.
